// File: rtl/commit_trace_merge_pkg.sv
// Shared types for the dual-thread commit trace merger: the RVFI-style commit
// packet carried through the FIFOs and the thread identifier on the trace port.
package commit_trace_merge_pkg;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
    } rvfi_commit_packet_t;

    typedef logic [0:0] trace_tid_t;

    // Order value the next in-sequence commit of a thread must carry.
    function automatic logic [63:0] next_order(input logic [63:0] order);
        return order + 64'd1;
    endfunction

endpackage

// File: rtl/commit_trace_merge_fifo.sv
// Per-thread commit FIFO with wrap-bit pointers; push while full is taken
// only when the same cycle also pops, so occupancy stays unchanged.
module commit_fifo
    import commit_trace_merge_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  rvfi_commit_packet_t push_data,
    input  logic                pop,
    output rvfi_commit_packet_t head,
    output logic                empty,
    output logic                full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [AW:0]         wr_ptr_r;
    logic [AW:0]         rd_ptr_r;
    rvfi_commit_packet_t mem_r [DEPTH];
    logic                do_push_s;
    logic                do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer advance; reset empties the FIFO in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_INC;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
        end
    end

    // Storage write; contents are meaningless until the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/commit_trace_merge.sv
// Merges two non-stallable per-thread retire streams into one valid/ready
// trace port via a locked round-robin arbiter, with counters and sticky checks.
module commit_trace_merge
    import commit_trace_merge_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                t0_valid,
    input  rvfi_commit_packet_t t0_pkt,
    input  logic                t1_valid,
    input  rvfi_commit_packet_t t1_pkt,
    input  logic                swap,
    output logic                out_valid,
    input  logic                out_ready,
    output rvfi_commit_packet_t out_pkt,
    output trace_tid_t          out_tid,
    output logic [63:0]         t0_count,
    output logic [63:0]         t1_count,
    output logic [1:0]          overflow,
    output logic [1:0]          order_err
);

    rvfi_commit_packet_t head0_s;
    rvfi_commit_packet_t head1_s;
    logic [1:0]          empty_s;
    logic [1:0]          full_s;
    logic [1:0]          pop_s;
    logic [1:0]          push_s;
    logic [1:0]          drop_s;
    logic [1:0]          in_valid_s;
    logic [63:0]         in_order_s [2];
    trace_tid_t          grant_s;
    logic                valid_s;
    logic                handshake_s;

    trace_tid_t          last_r;
    trace_tid_t          grant_r;
    logic                lock_r;
    logic [63:0]         t0_count_r;
    logic [63:0]         t1_count_r;
    logic [1:0]          overflow_r;
    logic [1:0]          order_err_r;
    logic [1:0]          armed_r;
    logic [63:0]         exp_r [2];

    commit_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s[0]),
        .push_data (t0_pkt),
        .pop       (pop_s[0]),
        .head      (head0_s),
        .empty     (empty_s[0]),
        .full      (full_s[0])
    );

    commit_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s[1]),
        .push_data (t1_pkt),
        .pop       (pop_s[1]),
        .head      (head1_s),
        .empty     (empty_s[1]),
        .full      (full_s[1])
    );

    // Grant selection: a held grant wins, otherwise round-robin on ties.
    always_comb begin
        grant_s = 1'b0;
        if (lock_r) begin
            grant_s = grant_r;
        end else if (!empty_s[0] && !empty_s[1]) begin
            grant_s = ~last_r;
        end else if (!empty_s[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign valid_s     = grant_s ? !empty_s[1] : !empty_s[0];
    assign handshake_s = valid_s && out_ready;
    assign pop_s       = handshake_s ? (grant_s ? 2'b10 : 2'b01) : 2'b00;
    assign in_valid_s  = {t1_valid, t0_valid};
    assign in_order_s[0] = t0_pkt.order;
    assign in_order_s[1] = t1_pkt.order;
    // A full FIFO only accepts when its head leaves in the same cycle.
    assign push_s      = in_valid_s & (~full_s | pop_s);
    assign drop_s      = in_valid_s & full_s & ~pop_s;

    assign out_valid = valid_s;
    assign out_tid   = grant_s;
    assign out_pkt   = valid_s ? (grant_s ? head1_s : head0_s) : '0;
    assign t0_count  = t0_count_r;
    assign t1_count  = t1_count_r;
    assign overflow  = overflow_r;
    assign order_err = order_err_r;

    // Arbiter state: lock while the consumer stalls, rotate on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r  <= 1'b1;
            grant_r <= 1'b0;
            lock_r  <= 1'b0;
        end else if (handshake_s) begin
            last_r  <= grant_s;
            lock_r  <= 1'b0;
        end else if (valid_s) begin
            grant_r <= grant_s;
            lock_r  <= 1'b1;
        end
    end

    // Accepted-commit counters and sticky drop flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            t0_count_r <= 64'd0;
            t1_count_r <= 64'd0;
            overflow_r <= 2'b00;
        end else begin
            if (push_s[0]) begin
                t0_count_r <= t0_count_r + 64'd1;
            end
            if (push_s[1]) begin
                t1_count_r <= t1_count_r + 64'd1;
            end
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Order checkers see dropped packets too; swap disarms before the check.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_r     <= 2'b00;
            exp_r[0]    <= 64'd0;
            exp_r[1]    <= 64'd0;
            order_err_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (in_valid_s[i]) begin
                    if (armed_r[i] && !swap && (in_order_s[i] != exp_r[i])) begin
                        order_err_r[i] <= 1'b1;
                    end
                    armed_r[i] <= 1'b1;
                    exp_r[i]   <= next_order(in_order_s[i]);
                end else if (swap) begin
                    armed_r[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_merge.sv
// Self-checking bench for commit_trace_merge: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_commit_trace_merge;
    import commit_trace_merge_pkg::*;

    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                t0_valid = 1'b0;
    rvfi_commit_packet_t t0_pkt = '0;
    logic                t1_valid = 1'b0;
    rvfi_commit_packet_t t1_pkt = '0;
    logic                swap = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    rvfi_commit_packet_t out_pkt;
    trace_tid_t          out_tid;
    logic [63:0]         t0_count;
    logic [63:0]         t1_count;
    logic [1:0]          overflow;
    logic [1:0]          order_err;

    int checks = 0;
    int failures = 0;

    commit_trace_merge #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .t0_valid  (t0_valid),
        .t0_pkt    (t0_pkt),
        .t1_valid  (t1_valid),
        .t1_pkt    (t1_pkt),
        .swap      (swap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pkt   (out_pkt),
        .out_tid   (out_tid),
        .t0_count  (t0_count),
        .t1_count  (t1_count),
        .overflow  (overflow),
        .order_err (order_err)
    );

    always #5 clk = ~clk;

    // Reference model state: plain queues plus the arbitration rules.
    rvfi_commit_packet_t mq0 [$];
    rvfi_commit_packet_t mq1 [$];
    logic        m_last = 1'b1;
    logic        m_locked = 1'b0;
    logic        m_held = 1'b0;
    logic [63:0] m_cnt [2];
    logic [1:0]  m_ov = 2'b00;
    logic [1:0]  m_oe = 2'b00;
    logic [1:0]  m_armed = 2'b00;
    logic [63:0] m_exp [2];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic rvfi_commit_packet_t mk(input logic [63:0] o);
        rvfi_commit_packet_t p;
        p.order    = o;
        p.insn     = $urandom;
        p.pc_rdata = $urandom;
        p.pc_wdata = $urandom;
        p.rd_addr  = 5'($urandom);
        p.rd_wdata = $urandom;
        return p;
    endfunction

    function automatic int qsize(input logic t);
        return t ? mq1.size() : mq0.size();
    endfunction

    function automatic logic m_grant();
        if (m_locked) return m_held;
        if (mq0.size() > 0 && mq1.size() > 0) return ~m_last;
        if (mq1.size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic rs, input logic [1:0] v,
                              input rvfi_commit_packet_t p0, input rvfi_commit_packet_t p1,
                              input logic sw, input logic rdy);
        logic       g;
        logic       ov;
        logic       fire;
        logic [1:0] acc;
        logic [63:0] o;
        if (rs) begin
            mq0.delete();
            mq1.delete();
            m_last = 1'b1; m_locked = 1'b0; m_held = 1'b0;
            m_cnt[0] = 64'd0; m_cnt[1] = 64'd0;
            m_ov = 2'b00; m_oe = 2'b00; m_armed = 2'b00;
            return;
        end
        g    = m_grant();
        ov   = qsize(g) > 0;
        fire = ov && rdy;
        acc[0] = v[0] && (mq0.size() < DEPTH || (fire && !g));
        acc[1] = v[1] && (mq1.size() < DEPTH || (fire && g));
        if (fire) begin
            if (g) void'(mq1.pop_front());
            else   void'(mq0.pop_front());
            m_last = g;
            m_locked = 1'b0;
        end else if (ov) begin
            m_locked = 1'b1;
            m_held = g;
        end
        if (acc[0]) begin mq0.push_back(p0); m_cnt[0] = m_cnt[0] + 64'd1; end
        else if (v[0]) m_ov[0] = 1'b1;
        if (acc[1]) begin mq1.push_back(p1); m_cnt[1] = m_cnt[1] + 64'd1; end
        else if (v[1]) m_ov[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            o = (t == 0) ? p0.order : p1.order;
            if (v[t]) begin
                if (sw || !m_armed[t]) m_armed[t] = 1'b1;
                else if (o != m_exp[t]) m_oe[t] = 1'b1;
                m_exp[t] = o + 64'd1;
            end else if (sw) begin
                m_armed[t] = 1'b0;
            end
        end
    endtask

    task automatic compare_model();
        logic g;
        logic ev;
        g  = m_grant();
        ev = qsize(g) > 0;
        chk("model_valid", 256'(out_valid), 256'(ev));
        if (ev) begin
            chk("model_tid", 256'(out_tid), 256'(g));
            chk("model_pkt", 256'(out_pkt), g ? 256'(mq1[0]) : 256'(mq0[0]));
        end
        chk("model_t0_count", 256'(t0_count), 256'(m_cnt[0]));
        chk("model_t1_count", 256'(t1_count), 256'(m_cnt[1]));
        chk("model_overflow", 256'(overflow), 256'(m_ov));
        chk("model_order_err", 256'(order_err), 256'(m_oe));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic step(input logic rs, input logic v0, input logic [63:0] o0,
                        input logic v1, input logic [63:0] o1,
                        input logic sw, input logic rdy);
        rvfi_commit_packet_t p0;
        rvfi_commit_packet_t p1;
        p0 = mk(o0);
        p1 = mk(o1);
        rst = rs; t0_valid = v0; t0_pkt = p0; t1_valid = v1; t1_pkt = p1;
        swap = sw; out_ready = rdy;
        @(posedge clk);
        model_step(rs, {v1, v0}, p0, p1, sw, rdy);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic        rs, v0;
        logic [63:0] o0;
        logic        v1;
        logic [63:0] o1;
        logic        sw, rdy;
        logic        ev, et;
        logic [63:0] eo, ec0, ec1;
        logic [1:0]  eov, eoe;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic rs, input logic v0, input logic [63:0] o0,
                       input logic v1, input logic [63:0] o1, input logic sw, input logic rdy,
                       input logic ev, input logic et, input logic [63:0] eo,
                       input logic [63:0] ec0, input logic [63:0] ec1);
        vec_t r;
        r.rs = rs; r.v0 = v0; r.o0 = o0; r.v1 = v1; r.o1 = o1; r.sw = sw; r.rdy = rdy;
        r.ev = ev; r.et = et; r.eo = eo; r.ec0 = ec0; r.ec1 = ec1;
        r.eov = 2'b00; r.eoe = 2'b00;
        tbl.push_back(r);
    endtask

    logic [63:0] nxt [2];
    logic        rv0, rv1;
    logic [63:0] ro0, ro1;

    initial begin
        m_cnt[0] = 64'd0; m_cnt[1] = 64'd0;
        m_exp[0] = 64'd0; m_exp[1] = 64'd0;

        // Single thread: orders 0,1,2 appear on consecutive cycles.
        add(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        add(1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 64'd1, 64'd0);
        add(1'b0, 1'b1, 64'd1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd1, 64'd2, 64'd0);
        add(1'b0, 1'b1, 64'd2, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd2, 64'd3, 64'd0);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd3, 64'd0);
        // Tie: thread 0 first after reset, then alternating.
        add(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        add(1'b0, 1'b1, 64'd0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd1, 64'd1);
        add(1'b0, 1'b1, 64'd1, 1'b1, 64'd1, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd2, 64'd2);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd0, 64'd2, 64'd2);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd1, 64'd2, 64'd2);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd1, 64'd2, 64'd2);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd2, 64'd2);
        // Stall: grant held on thread 0 while thread 1 fills, then thread 1.
        add(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
        add(1'b0, 1'b1, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd1, 64'd0);
        add(1'b0, 1'b0, 64'd0, 1'b1, 64'd7, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd1, 64'd1);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd1, 64'd1);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 64'd1, 64'd1);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 64'd7, 64'd1, 64'd1);
        add(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd1, 64'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rs, tbl[i].v0, tbl[i].o0, tbl[i].v1, tbl[i].o1, tbl[i].sw, tbl[i].rdy);
            chk("vec_valid", 256'(out_valid), 256'(tbl[i].ev));
            if (tbl[i].ev || tbl[i].rs) begin
                chk("vec_tid", 256'(out_tid), 256'(tbl[i].et));
                chk("vec_order", 256'(out_pkt.order), 256'(tbl[i].eo));
            end
            if (tbl[i].rs) chk("vec_reset_pkt", 256'(out_pkt), 256'd0);
            chk("vec_t0_count", 256'(t0_count), 256'(tbl[i].ec0));
            chk("vec_t1_count", 256'(t1_count), 256'(tbl[i].ec1));
            chk("vec_overflow", 256'(overflow), 256'(tbl[i].eov));
            chk("vec_order_err", 256'(order_err), 256'(tbl[i].eoe));
        end

        // Overflow: fifth push into a stalled full FIFO is dropped.
        step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 64'(i), 1'b0, 64'd0, 1'b0, 1'b0);
        chk("ovf_t0_count", 256'(t0_count), 256'd4);
        chk("ovf_flag", 256'(overflow), 256'(2'b01));
        chk("ovf_order_err", 256'(order_err), 256'(2'b00));
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain_order", 256'(out_pkt.order), 256'(i));
            step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1);
        end
        chk("ovf_drained", 256'(out_valid), 256'd0);

        // Full plus pop in the same cycle: push accepted, no drop.
        step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 64'(i), 1'b0, 64'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 64'd4, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("fpp_overflow", 256'(overflow), 256'(2'b00));
        chk("fpp_t0_count", 256'(t0_count), 256'd5);
        for (int i = 1; i < 5; i++) begin
            chk("fpp_drain_order", 256'(out_pkt.order), 256'(i));
            step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1);
        end

        // Order checking and swap re-arming.
        step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'd10, 1'b0, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'd11, 1'b0, 1'b1);
        chk("ord_in_seq", 256'(order_err), 256'(2'b00));
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'd13, 1'b0, 1'b1);
        chk("ord_gap", 256'(order_err), 256'(2'b10));
        step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'd50, 1'b0, 1'b1);
        chk("ord_after_swap", 256'(order_err), 256'(2'b10));
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'd70, 1'b1, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'd71, 1'b0, 1'b1);
        chk("ord_swap_with_push", 256'(order_err), 256'(2'b10));
        step(1'b0, 1'b1, 64'd5, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("ord_t0_first", 256'(order_err), 256'(2'b10));
        step(1'b0, 1'b1, 64'd7, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("ord_t0_gap", 256'(order_err), 256'(2'b11));

        // Randomized traffic against the model.
        step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
        nxt[0] = 64'd0;
        nxt[1] = 64'd1000;
        for (int n = 0; n < 3000; n++) begin
            rv0 = $urandom_range(0, 9) < 6;
            rv1 = $urandom_range(0, 9) < 6;
            ro0 = nxt[0] + (($urandom_range(0, 19) == 0) ? 64'd3 : 64'd0);
            ro1 = nxt[1] + (($urandom_range(0, 19) == 0) ? 64'd3 : 64'd0);
            if (rv0) nxt[0] = ro0 + 64'd1;
            if (rv1) nxt[1] = ro1 + 64'd1;
            step(($urandom_range(0, 499) == 0), rv0, ro0, rv1, ro1,
                 ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
